// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//
// Shared definitions for the iterative multiply/divide sequencer.
//
//   state_t  : sequencer states, IDLE through EXC
//   OP_MULT  : op encoding for multiply (0)
//   OP_DIV   : op encoding for divide   (1)
// ---------------------------------------------------------------------------
package muldiv_pkg;

  // Sequencer states. IDLE is the only state in which busy is low.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREP   = 3'd1,
    RUN    = 3'd2,
    FIX    = 3'd3,
    COMMIT = 3'd4,
    EXC    = 3'd5
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//
// One combinational iteration of an unsigned radix-2 multiply or divide.
// The sequencer keeps a double-width working register {hi, lo} and feeds it
// through this block once per RUN cycle.
//
//   op       : OP_MULT selects shift-add, OP_DIV selects restoring divide
//   hi       : upper working half (partial product / partial remainder)
//   lo       : lower working half (multiplier bits / dividend-quotient bits)
//   operand  : multiplicand magnitude or divisor magnitude
//   hi_next  : updated upper half
//   lo_next  : updated lower half
// ---------------------------------------------------------------------------
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: the LSB of lo is the current multiplier bit. When it is set
  // the multiplicand is added into hi, and the whole {carry, hi, lo} moves
  // right by one so the consumed multiplier bit falls off the bottom.
  //
  // Divide: {hi, lo} shifts left by one, pulling the next dividend bit into
  // the partial remainder. If the divisor fits, it is subtracted and a 1 is
  // shifted into the quotient; otherwise the shifted remainder is kept.
  // The partial remainder always stays below the divisor, so diff[WIDTH]
  // is set exactly when the trial subtraction borrows.
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, operand};
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    hi_next = hi;
    lo_next = lo;

    if (op == OP_DIV) begin
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
      end else begin
        hi_next = {1'b0, hi[WIDTH-1:1]};
        lo_next = {hi[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide unit with HI/LO result registers. Operands are
// captured on start, reduced to magnitudes, iterated WIDTH times through
// muldiv_step, sign corrected, then committed to HI/LO with a one-cycle
// done/hilo_we pulse. A divide by zero skips the iteration and pulses Div0.
//
//   clock     : rising-edge clock
//   RESET_n   : asynchronous active-low reset
//   start     : launch an operation (honoured only in IDLE, abort low)
//   op        : 0 = multiply, 1 = divide
//   is_signed : operands are two's complement when high
//   abort     : cancel the operation in progress, return to IDLE
//   A, B      : multiplicand/multiplier or dividend/divisor
//   busy      : high in every state other than IDLE
//   done      : one-cycle pulse when HI/LO are written
//   hilo_we   : HI/LO write strobe, coincident with done
//   Div0      : one-cycle pulse on divide by zero
//   HI, LO    : product upper/lower half, or remainder/quotient
// ---------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             RESET_n,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic             Div0,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operands as captured on the launching edge
  logic             op_q;
  logic             signed_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Iteration datapath
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] hi_acc;
  logic [WIDTH-1:0] lo_acc;
  logic             neg_q;
  logic             neg_r;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Magnitudes of the captured operands. The most negative value maps to
  // 2^(WIDTH-1), which still fits in an unsigned WIDTH-bit field, so
  // MIN / -1 comes out as the MIN bit pattern without special handling.
  always_comb begin
    sign_a = signed_q & a_q[WIDTH-1];
    sign_b = signed_q & b_q[WIDTH-1];
    mag_a  = sign_a ? -a_q : a_q;
    mag_b  = sign_b ? -b_q : b_q;
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op      (op_q),
    .hi      (hi_acc),
    .lo      (lo_acc),
    .operand (operand_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign correction of the unsigned iteration result. A product is negated
  // as a full double-width value. For a divide the quotient follows the
  // XOR of the operand signs (truncation toward zero) and the remainder
  // follows the sign of the dividend.
  always_comb begin
    prod     = {hi_acc, lo_acc};
    prod_neg = -prod;
    fix_hi   = hi_acc;
    fix_lo   = lo_acc;
    if (op_q == OP_MULT) begin
      if (neg_q) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end else begin
      if (neg_q) begin
        fix_lo = -lo_acc;
      end
      if (neg_r) begin
        fix_hi = -hi_acc;
      end
    end
  end

  // Sequencer. All outputs are registered here alongside the state so that
  // busy/done/hilo_we/Div0 change only on clock edges (or reset). The
  // result is written to HI/LO on the FIX->COMMIT edge, so HI/LO already
  // show the new value during the cycle in which done is high. Abort from
  // any busy state wins over everything else and leaves HI/LO untouched.
  always_ff @(posedge clock or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_MULT;
      signed_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      operand_q <= '0;
      hi_acc    <= '0;
      lo_acc    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hilo_we   <= 1'b0;
      Div0      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      done    <= 1'b0;
      hilo_we <= 1'b0;
      Div0    <= 1'b0;

      if (state != IDLE && abort) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              op_q     <= op;
              signed_q <= is_signed;
              a_q      <= A;
              b_q      <= B;
              busy     <= 1'b1;
              state    <= PREP;
            end
          end

          PREP: begin
            hi_acc    <= '0;
            lo_acc    <= mag_a;
            operand_q <= mag_b;
            neg_q     <= sign_a ^ sign_b;
            neg_r     <= sign_a;
            cnt       <= CNT_W'(WIDTH);
            if (op_q == OP_DIV && b_q == '0) begin
              Div0  <= 1'b1;
              state <= EXC;
            end else begin
              state <= RUN;
            end
          end

          // The counter enters at WIDTH and the final iteration runs with
          // it at 1, giving exactly WIDTH iterations.
          RUN: begin
            hi_acc <= step_hi;
            lo_acc <= step_lo;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= FIX;
            end
          end

          FIX: begin
            HI      <= fix_hi;
            LO      <= fix_lo;
            done    <= 1'b1;
            hilo_we <= 1'b1;
            state   <= COMMIT;
          end

          COMMIT: begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end

          EXC: begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer. A 32-bit instance carries the
// directed table, random operations, abort and reset sequences; an 8-bit
// instance covers the small-width MIN / -1 case and a few random ops.
// Expected results come from plain integer arithmetic on sign-extended
// operands.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clock   = 1'b0;
  logic        RESET_n = 1'b0;

  logic        start = 1'b0, op = 1'b0, is_signed = 1'b0, abort = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, hilo_we, Div0;
  logic [31:0] HI, LO;

  logic        start_8 = 1'b0, op_8 = 1'b0, is_signed_8 = 1'b0, abort_8 = 1'b0;
  logic [7:0]  A_8 = '0, B_8 = '0;
  logic        busy_8, done_8, hilo_we_8, Div0_8;
  logic [7:0]  HI_8, LO_8;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent operation
  logic [63:0] obs_hi, obs_lo;
  int obs_done_n, obs_done_cyc, obs_we_n, obs_we_cyc;
  int obs_div0_n, obs_div0_cyc, obs_busy_n;

  // Last committed result the bench expects each instance to hold
  logic [63:0] held_hi32 = '0, held_lo32 = '0;
  logic [63:0] held_hi8  = '0, held_lo8  = '0;

  typedef struct {
    bit          op;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          exp_div0;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer dut (
    .clock     (clock),
    .RESET_n   (RESET_n),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .abort     (abort),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .Div0      (Div0),
    .HI        (HI),
    .LO        (LO)
  );

  muldiv_sequencer #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .RESET_n   (RESET_n),
    .start     (start_8),
    .op        (op_8),
    .is_signed (is_signed_8),
    .abort     (abort_8),
    .A         (A_8),
    .B         (B_8),
    .busy      (busy_8),
    .done      (done_8),
    .hilo_we   (hilo_we_8),
    .Div0      (Div0_8),
    .HI        (HI_8),
    .LO        (LO_8)
  );

  always #5 clock = ~clock;

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic: sign- or zero-extend to 64 bits, then use the
  // language's own *, / and % (which truncate toward zero and give the
  // remainder the dividend's sign).
  function automatic void refModel(input bit op_i, input bit sgn_i,
                                   input logic [31:0] a_i, input logic [31:0] b_i,
                                   input int w,
                                   output logic [63:0] hi_o, output logic [63:0] lo_o);
    longint      ea, eb, q, r;
    logic [63:0] mask, p;
    mask = (64'd1 << w) - 64'd1;
    ea = longint'({32'b0, a_i} & mask);
    eb = longint'({32'b0, b_i} & mask);
    if (sgn_i && a_i[w-1]) ea = ea - (longint'(1) << w);
    if (sgn_i && b_i[w-1]) eb = eb - (longint'(1) << w);
    if (op_i == OP_MULT) begin
      p    = ea * eb;
      lo_o = p & mask;
      hi_o = (p >> w) & mask;
    end else begin
      q    = ea / eb;
      r    = ea % eb;
      lo_o = q & mask;
      hi_o = r & mask;
    end
  endfunction

  // Launch one operation and watch it for WIDTH+6 cycles. Cycle 0 is the
  // cycle in which start is presented; outputs are sampled on falling
  // edges. The operand inputs are scrambled after launch so that any
  // re-sampling would corrupt the result.
  task automatic applyStimulus(input bit use8, input bit op_i, input bit sgn_i,
                               input logic [31:0] a_i, input logic [31:0] b_i);
    int w = use8 ? 8 : 32;
    obs_done_n = 0; obs_done_cyc = -1; obs_we_n = 0; obs_we_cyc = -1;
    obs_div0_n = 0; obs_div0_cyc = -1; obs_busy_n = 0;
    @(negedge clock);
    if (use8) begin
      start_8 = 1'b1; op_8 = op_i; is_signed_8 = sgn_i; A_8 = a_i[7:0]; B_8 = b_i[7:0];
    end else begin
      start = 1'b1; op = op_i; is_signed = sgn_i; A = a_i; B = b_i;
    end
    for (int c = 1; c <= w + 6; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0; start_8 = 1'b0;
        A = $urandom; B = $urandom; A_8 = 8'($urandom); B_8 = 8'($urandom);
        op = ~op_i; op_8 = ~op_i; is_signed = ~sgn_i; is_signed_8 = ~sgn_i;
      end
      if (use8 ? done_8 : done) begin obs_done_n++; obs_done_cyc = c; end
      if (use8 ? hilo_we_8 : hilo_we) begin obs_we_n++; obs_we_cyc = c; end
      if (use8 ? Div0_8 : Div0) begin obs_div0_n++; obs_div0_cyc = c; end
      if (use8 ? busy_8 : busy) obs_busy_n++;
    end
    obs_hi = use8 ? {56'b0, HI_8} : {32'b0, HI};
    obs_lo = use8 ? {56'b0, LO_8} : {32'b0, LO};
  endtask

  task automatic verifyOp(input string name, input int w, input bit exp_div0,
                          input logic [63:0] exp_hi, input logic [63:0] exp_lo);
    checkOutput({name, " HI"}, obs_hi, exp_hi);
    checkOutput({name, " LO"}, obs_lo, exp_lo);
    if (exp_div0) begin
      checkOutput({name, " Div0 pulses"}, obs_div0_n, 1);
      checkOutput({name, " Div0 cycle"}, obs_div0_cyc, 2);
      checkOutput({name, " done pulses"}, obs_done_n, 0);
      checkOutput({name, " hilo_we pulses"}, obs_we_n, 0);
      checkOutput({name, " busy cycles"}, obs_busy_n, 2);
    end else begin
      checkOutput({name, " done pulses"}, obs_done_n, 1);
      checkOutput({name, " done cycle"}, obs_done_cyc, w + 3);
      checkOutput({name, " hilo_we pulses"}, obs_we_n, 1);
      checkOutput({name, " hilo_we cycle"}, obs_we_cyc, obs_done_cyc);
      checkOutput({name, " Div0 pulses"}, obs_div0_n, 0);
      checkOutput({name, " busy cycles"}, obs_busy_n, w + 3);
    end
  endtask

  task automatic runModelOp(input string name, input bit use8, input bit op_i,
                            input bit sgn_i, input logic [31:0] a_i, input logic [31:0] b_i);
    int          w = use8 ? 8 : 32;
    logic [31:0] bm = use8 ? {24'b0, b_i[7:0]} : b_i;
    bit          dz = (op_i == OP_DIV) && (bm == 32'd0);
    logic [63:0] eh, el;
    applyStimulus(use8, op_i, sgn_i, a_i, b_i);
    if (dz) begin
      eh = use8 ? held_hi8 : held_hi32;
      el = use8 ? held_lo8 : held_lo32;
    end else begin
      refModel(op_i, sgn_i, a_i, b_i, w, eh, el);
      if (use8) begin held_hi8 = eh; held_lo8 = el; end
      else begin held_hi32 = eh; held_lo32 = el; end
    end
    verifyOp(name, w, dz, eh, el);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rop, rsg;
    int          n_done, n_we, n_div0, n_busy_after;

    // Directed table for the 32-bit instance
    vecs[0] = '{OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{OP_DIV,  1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3] = '{OP_DIV,  1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[5] = '{OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{OP_DIV,  1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    vecs[7] = '{OP_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8] = '{OP_DIV,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[9] = '{OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

    // Power-up reset
    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset hilo_we", hilo_we, 0);
    checkOutput("reset Div0", Div0, 0);
    checkOutput("reset HI", HI, 0);
    checkOutput("reset LO", LO, 0);
    checkOutput("reset busy_8", busy_8, 0);
    @(negedge clock);
    RESET_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
      verifyOp($sformatf("vec%0d", i), 32, vecs[i].exp_div0,
               {32'b0, vecs[i].exp_hi}, {32'b0, vecs[i].exp_lo});
      if (!vecs[i].exp_div0) begin
        held_hi32 = {32'b0, vecs[i].exp_hi};
        held_lo32 = {32'b0, vecs[i].exp_lo};
      end
    end

    // Random 32-bit operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      runModelOp($sformatf("rand32_%0d", i), 1'b0, rop, rsg, ra, rb);
    end

    // 8-bit instance: MIN / -1, then random ops
    applyStimulus(1'b1, OP_DIV, 1'b1, 32'h80, 32'hFF);
    verifyOp("w8 min/-1", 8, 1'b0, 64'h00, 64'h80);
    held_hi8 = 64'h00; held_lo8 = 64'h80;
    for (int i = 0; i < 12; i++) begin
      rb = (i % 4 == 3) ? 32'd0 : $urandom;
      runModelOp($sformatf("rand8_%0d", i), 1'b1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, rb);
    end

    // Abort beats start in IDLE
    @(negedge clock);
    start = 1'b1; abort = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd3;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort over start busy", busy, 0);
    repeat (3) @(negedge clock);
    checkOutput("abort over start still idle", busy, 0);

    // Abort in RUN cycle 5 with an ignored start while busy
    n_done = 0; n_we = 0; n_div0 = 0; n_busy_after = 0;
    @(negedge clock);
    start = 1'b1; op = OP_MULT; is_signed = 1'b0; A = 32'd5; B = 32'd6;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      if (done) n_done++;
      if (hilo_we) n_we++;
      if (Div0) n_div0++;
      if (c >= 7 && busy) n_busy_after++;
      if (c == 6) checkOutput("abort busy in RUN", busy, 1);
      if (c == 7) checkOutput("abort back to idle", busy, 0);
      case (c)
        1: start = 1'b0;
        3: start = 1'b1;
        4: start = 1'b0;
        6: abort = 1'b1;
        7: abort = 1'b0;
        default: ;
      endcase
    end
    checkOutput("abort done pulses", n_done, 0);
    checkOutput("abort hilo_we pulses", n_we, 0);
    checkOutput("abort Div0 pulses", n_div0, 0);
    checkOutput("abort ignored start busy", n_busy_after, 0);
    checkOutput("abort HI held", {32'b0, HI}, held_hi32);
    checkOutput("abort LO held", {32'b0, LO}, held_lo32);

    // Reset mid-RUN, then a fresh 3*4
    runModelOp("pre-reset mult", 1'b0, OP_MULT, 1'b0, 32'h1234, 32'h10);
    @(negedge clock);
    start = 1'b1; op = OP_MULT; is_signed = 1'b0; A = 32'd7; B = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 RESET_n = 1'b0;
    #1;
    checkOutput("midrun reset busy", busy, 0);
    checkOutput("midrun reset done", done, 0);
    checkOutput("midrun reset hilo_we", hilo_we, 0);
    checkOutput("midrun reset Div0", Div0, 0);
    checkOutput("midrun reset HI", HI, 0);
    checkOutput("midrun reset LO", LO, 0);
    @(negedge clock);
    RESET_n = 1'b1;
    held_hi32 = '0; held_lo32 = '0; held_hi8 = '0; held_lo8 = '0;
    applyStimulus(1'b0, OP_MULT, 1'b0, 32'd3, 32'd4);
    verifyOp("post-reset 3*4", 32, 1'b0, 64'd0, 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
